// File: rtl/iob_arbiter.sv
// Two-requester IOB arbiter sharing one memory-side IOB port.
// Define IOB_ARB_ROUND_ROBIN_EN for round-robin; default is fixed priority (requester 1 wins).
module iob_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_valid_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [DATA_W-1:0] m0_wdata_i,
    input  logic [DATA_W/8-1:0] m0_wstrb_i,
    output logic              m0_ready_o,
    output logic [DATA_W-1:0] m0_rdata_o,
    input  logic              m1_valid_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [DATA_W-1:0] m1_wdata_i,
    input  logic [DATA_W/8-1:0] m1_wstrb_i,
    output logic              m1_ready_o,
    output logic [DATA_W-1:0] m1_rdata_o,
    output logic              s_valid_o,
    output logic [ADDR_W-1:0] s_addr_o,
    output logic [DATA_W-1:0] s_wdata_o,
    output logic [DATA_W/8-1:0] s_wstrb_o,
    input  logic              s_ready_i,
    input  logic [DATA_W-1:0] s_rdata_i,
    output logic [1:0]        grant_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic pick0, pick1;

    logic              s_valid_q;
    logic [ADDR_W-1:0] s_addr_q;
    logic [DATA_W-1:0] s_wdata_q;
    logic [DATA_W/8-1:0] s_wstrb_q;

`ifdef IOB_ARB_ROUND_ROBIN_EN
    // last_q high means requester 1 owned the most recent grant
    logic last_q, last_d;

    always_comb begin
        pick1 = m1_valid_i & (~m0_valid_i | ~last_q);
        pick0 = m0_valid_i & ~pick1;
        last_d = last_q;
        if (state_q == IDLE && (pick0 || pick1)) begin
            last_d = pick1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`else
    always_comb begin
        pick1 = m1_valid_i;
        pick0 = m0_valid_i & ~m1_valid_i;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (pick1) begin
                    state_d = GRANT1;
                end else if (pick0) begin
                    state_d = GRANT0;
                end
            end
            GRANT0, GRANT1: begin
                if (s_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Request is captured only on the IDLE->GRANT edge, so later requester changes are ignored
    always_ff @(posedge clk) begin
        if (reset) begin
            s_valid_q <= 1'b0;
            s_addr_q  <= '0;
            s_wdata_q <= '0;
            s_wstrb_q <= '0;
        end else begin
            s_valid_q <= (state_d != IDLE);
            if (state_q == IDLE) begin
                if (pick1) begin
                    s_addr_q  <= m1_addr_i;
                    s_wdata_q <= m1_wdata_i;
                    s_wstrb_q <= m1_wstrb_i;
                end else if (pick0) begin
                    s_addr_q  <= m0_addr_i;
                    s_wdata_q <= m0_wdata_i;
                    s_wstrb_q <= m0_wstrb_i;
                end
            end
        end
    end

    always_comb begin
        grant_o    = 2'b00;
        m0_ready_o = 1'b0;
        m1_ready_o = 1'b0;
        unique case (state_q)
            GRANT0: begin
                grant_o    = 2'b01;
                m0_ready_o = s_ready_i & ~reset;
            end
            GRANT1: begin
                grant_o    = 2'b10;
                m1_ready_o = s_ready_i & ~reset;
            end
            default: grant_o = 2'b00;
        endcase
    end

    assign m0_rdata_o = s_rdata_i;
    assign m1_rdata_o = s_rdata_i;
    assign s_valid_o  = s_valid_q;
    assign s_addr_o   = s_addr_q;
    assign s_wdata_o  = s_wdata_q;
    assign s_wstrb_o  = s_wstrb_q;

endmodule

// File: tb/tb_iob_arbiter.sv
// Directed testbench for iob_arbiter: reads, writes, stalls, contention, reset abort.
module tb_iob_arbiter;

    logic        clk;
    logic        reset;
    logic        m0_valid_i;
    logic [31:0] m0_addr_i;
    logic [31:0] m0_wdata_i;
    logic [3:0]  m0_wstrb_i;
    logic        m0_ready_o;
    logic [31:0] m0_rdata_o;
    logic        m1_valid_i;
    logic [31:0] m1_addr_i;
    logic [31:0] m1_wdata_i;
    logic [3:0]  m1_wstrb_i;
    logic        m1_ready_o;
    logic [31:0] m1_rdata_o;
    logic        s_valid_o;
    logic [31:0] s_addr_o;
    logic [31:0] s_wdata_o;
    logic [3:0]  s_wstrb_o;
    logic        s_ready_i;
    logic [31:0] s_rdata_i;
    logic [1:0]  grant_o;

    int checks = 0;
    int failures = 0;

    iob_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .m0_valid_i (m0_valid_i),
        .m0_addr_i  (m0_addr_i),
        .m0_wdata_i (m0_wdata_i),
        .m0_wstrb_i (m0_wstrb_i),
        .m0_ready_o (m0_ready_o),
        .m0_rdata_o (m0_rdata_o),
        .m1_valid_i (m1_valid_i),
        .m1_addr_i  (m1_addr_i),
        .m1_wdata_i (m1_wdata_i),
        .m1_wstrb_i (m1_wstrb_i),
        .m1_ready_o (m1_ready_o),
        .m1_rdata_o (m1_rdata_o),
        .s_valid_o  (s_valid_o),
        .s_addr_o   (s_addr_o),
        .s_wdata_o  (s_wdata_o),
        .s_wstrb_o  (s_wstrb_o),
        .s_ready_i  (s_ready_i),
        .s_rdata_i  (s_rdata_i),
        .grant_o    (grant_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [1:0] exp_grant [3];

    initial begin
        reset      = 1'b1;
        m0_valid_i = 1'b0;
        m0_addr_i  = '0;
        m0_wdata_i = '0;
        m0_wstrb_i = '0;
        m1_valid_i = 1'b0;
        m1_addr_i  = '0;
        m1_wdata_i = '0;
        m1_wstrb_i = '0;
        s_ready_i  = 1'b0;
        s_rdata_i  = '0;

        tick();
        tick();
        chk("rst_valid", 32'(s_valid_o), 32'd0);
        chk("rst_grant", 32'(grant_o), 32'd0);
        chk("rst_addr", s_addr_o, 32'd0);
        chk("rst_wdata", s_wdata_o, 32'd0);
        chk("rst_wstrb", 32'(s_wstrb_o), 32'd0);
        chk("rst_rdy0", 32'(m0_ready_o), 32'd0);
        chk("rst_rdy1", 32'(m1_ready_o), 32'd0);
        reset = 1'b0;

        // single read from requester 0
        m0_valid_i = 1'b1;
        m0_addr_i  = 32'h100;
        m0_wstrb_i = 4'h0;
        tick();
        chk("rd_valid", 32'(s_valid_o), 32'd1);
        chk("rd_addr", s_addr_o, 32'h100);
        chk("rd_wstrb", 32'(s_wstrb_o), 32'd0);
        chk("rd_grant", 32'(grant_o), 32'b01);
        chk("rd_rdy_wait", 32'(m0_ready_o), 32'd0);
        s_ready_i = 1'b1;
        s_rdata_i = 32'hDEADBEEF;
        #1;
        chk("rd_rdy0", 32'(m0_ready_o), 32'd1);
        chk("rd_rdy1", 32'(m1_ready_o), 32'd0);
        chk("rd_rdata", m0_rdata_o, 32'hDEADBEEF);
        tick();
        m0_valid_i = 1'b0;
        s_ready_i  = 1'b0;
        #1;
        chk("rd_done_valid", 32'(s_valid_o), 32'd0);
        chk("rd_done_grant", 32'(grant_o), 32'd0);
        chk("rd_done_rdy0", 32'(m0_ready_o), 32'd0);

        // single write from requester 1
        m1_valid_i = 1'b1;
        m1_addr_i  = 32'h2000;
        m1_wdata_i = 32'h12345678;
        m1_wstrb_i = 4'hF;
        tick();
        chk("wr_addr", s_addr_o, 32'h2000);
        chk("wr_wdata", s_wdata_o, 32'h12345678);
        chk("wr_wstrb", 32'(s_wstrb_o), 32'hF);
        chk("wr_grant", 32'(grant_o), 32'b10);
        s_ready_i = 1'b1;
        #1;
        chk("wr_rdy1", 32'(m1_ready_o), 32'd1);
        chk("wr_rdy0", 32'(m0_ready_o), 32'd0);
        tick();
        m1_valid_i = 1'b0;
        s_ready_i  = 1'b0;
        #1;
        chk("wr_done_valid", 32'(s_valid_o), 32'd0);
        chk("wr_done_rdy1", 32'(m1_ready_o), 32'd0);

        // stall for 5 cycles; requester input changes must not leak through
        m0_valid_i = 1'b1;
        m0_addr_i  = 32'h300;
        m0_wstrb_i = 4'h0;
        tick();
        m0_addr_i = 32'h999;
        for (int i = 0; i < 5; i++) begin
            chk("st_valid", 32'(s_valid_o), 32'd1);
            chk("st_addr", s_addr_o, 32'h300);
            chk("st_rdy0", 32'(m0_ready_o), 32'd0);
            tick();
        end
        s_ready_i = 1'b1;
        #1;
        chk("st_rdy0_pulse", 32'(m0_ready_o), 32'd1);
        tick();
        m0_valid_i = 1'b0;
        s_ready_i  = 1'b0;
        #1;
        chk("st_done_rdy0", 32'(m0_ready_o), 32'd0);
        chk("st_done_valid", 32'(s_valid_o), 32'd0);

        // contention with immediate s_ready; last grant was requester 0
`ifdef IOB_ARB_ROUND_ROBIN_EN
        exp_grant[0] = 2'b10;
        exp_grant[1] = 2'b01;
        exp_grant[2] = 2'b10;
`else
        exp_grant[0] = 2'b10;
        exp_grant[1] = 2'b10;
        exp_grant[2] = 2'b10;
`endif
        m0_valid_i = 1'b1;
        m0_addr_i  = 32'h400;
        m1_valid_i = 1'b1;
        m1_addr_i  = 32'h500;
        s_ready_i  = 1'b1;
        for (int r = 0; r < 3; r++) begin
            tick();
            chk("ct_grant", 32'(grant_o), 32'(exp_grant[r]));
            chk("ct_addr", s_addr_o, exp_grant[r][1] ? 32'h500 : 32'h400);
            chk("ct_rdy1", 32'(m1_ready_o), 32'(exp_grant[r][1]));
            chk("ct_rdy0", 32'(m0_ready_o), 32'(exp_grant[r][0]));
            tick();
            chk("ct_gap", 32'(s_valid_o), 32'd0);
        end
        m1_valid_i = 1'b0;
        tick();
        chk("ct_pending_grant", 32'(grant_o), 32'b01);
        chk("ct_pending_addr", s_addr_o, 32'h400);
        chk("ct_pending_rdy0", 32'(m0_ready_o), 32'd1);
        tick();
        m0_valid_i = 1'b0;
        #1;
        chk("ct_end_valid", 32'(s_valid_o), 32'd0);

        // back-to-back requests from requester 0
        m0_valid_i = 1'b1;
        m0_addr_i  = 32'h40;
        tick();
        chk("bb_first", 32'(s_valid_o), 32'd1);
        chk("bb_first_rdy", 32'(m0_ready_o), 32'd1);
        tick();
        chk("bb_gap", 32'(s_valid_o), 32'd0);
        chk("bb_gap_rdy", 32'(m0_ready_o), 32'd0);
        tick();
        chk("bb_second", 32'(s_valid_o), 32'd1);
        m0_valid_i = 1'b0;
        tick();
        chk("bb_end", 32'(s_valid_o), 32'd0);
        tick();
        chk("bb_quiet", 32'(s_valid_o), 32'd0);

        // reset while granted aborts the transfer
        s_ready_i  = 1'b0;
        m0_valid_i = 1'b1;
        m0_addr_i  = 32'h80;
        tick();
        chk("ra_grant", 32'(grant_o), 32'b01);
        reset = 1'b1;
        #1;
        chk("ra_rdy_before", 32'(m0_ready_o), 32'd0);
        tick();
        chk("ra_valid", 32'(s_valid_o), 32'd0);
        chk("ra_grant_idle", 32'(grant_o), 32'd0);
        chk("ra_addr", s_addr_o, 32'd0);
        chk("ra_rdy0", 32'(m0_ready_o), 32'd0);
        reset      = 1'b0;
        m0_valid_i = 1'b0;
        tick();
        chk("ra_after", 32'(s_valid_o), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
